dac_frame_scheduler: RTL and testbench

//  Sample-rate scheduler for the shared SPI DAC. It makes a 44.1 kHz frame tick from CLK_50MHZ and strobes the

---
 rtl/dac_frame_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_scheduler.sv
`timescale 1ns/1ps
// dac_frame_scheduler: 44.1 kHz frame tick plus a two-channel DAC word sequencer with a start/busy handshake.
// Optional macro SCHED_DROP_CNT_EN adds OUT_DROP_COUNT, a saturating count of dropped ticks.
module dac_frame_scheduler #(
    parameter int         TICK_DIV    = 1134,
    parameter int         LATCH_DELAY = 4,
    parameter int         ACK_TIMEOUT = 64,
    parameter logic [3:0] ADDR_A      = 4'h0,
    parameter logic [3:0] ADDR_B      = 4'h1
) (
    input  logic        CLK_50MHZ,
    input  logic        IN_RESET,
    input  logic        IN_ENABLE,
    input  logic [1:0]  IN_CH_MASK,
    input  logic [11:0] IN_SAMPLE_A,
    input  logic [11:0] IN_SAMPLE_B,
    input  logic        IN_DAC_BUSY,
    output logic        OUT_SAMPLE_TICK,
    output logic        OUT_DAC_START,
    output logic [11:0] OUT_DAC_BITS,
    output logic [3:0]  OUT_DAC_ADDR,
    output logic        OUT_FRAME_DONE,
    output logic        OUT_OVERRUN,
    output logic        OUT_TIMEOUT
`ifdef SCHED_DROP_CNT_EN
    ,
    output logic [7:0]  OUT_DROP_COUNT
`endif
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int DLY_W = (LATCH_DELAY > 0) ? $clog2(LATCH_DELAY + 1) : 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DLY_W-1:0]   dly_reg, dly_next;
    logic [ACK_W-1:0]   ack_reg, ack_next;
    logic [1:0]         pend_reg, pend_next;
    logic [11:0]        bits_reg, bits_next;
    logic [3:0]         addr_reg, addr_next;
    logic [11:0]        sample_a_reg, sample_b_reg;
    logic               overrun_reg, timeout_reg;

    logic               tick;
    logic               drop;
    logic               latch_en;
    logic               timeout_set;
    logic               advance;
    logic [1:0]         chan_src;
    logic [11:0]        word_a, word_b;

    assign tick = IN_ENABLE && (cnt_reg == CNT_W'(TICK_DIV - 1));
    assign drop = tick && (state_reg != IDLE);

    always_ff @(posedge CLK_50MHZ or posedge IN_RESET) begin
        if (IN_RESET) begin
            cnt_reg <= '0;
        end else if (!IN_ENABLE || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dly_next       = dly_reg;
        ack_next       = ack_reg;
        pend_next      = pend_reg;
        bits_next      = bits_reg;
        addr_next      = addr_reg;
        latch_en       = 1'b0;
        timeout_set    = 1'b0;
        advance        = 1'b0;
        chan_src       = pend_reg;
        word_a         = sample_a_reg;
        word_b         = sample_b_reg;
        OUT_DAC_START  = 1'b0;
        OUT_FRAME_DONE = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next = SETTLE;
                    dly_next   = '0;
                end
            end
            SETTLE: begin
                // The first word of the frame is taken straight from the inputs being latched.
                if (dly_reg == DLY_W'(LATCH_DELAY)) begin
                    latch_en = 1'b1;
                    chan_src = IN_CH_MASK;
                    word_a   = IN_SAMPLE_A;
                    word_b   = IN_SAMPLE_B;
                    advance  = 1'b1;
                end else begin
                    dly_next = dly_reg + 1'b1;
                end
            end
            ISSUE: begin
                OUT_DAC_START = 1'b1;
                state_next    = WAIT_ACK;
                ack_next      = ACK_W'(1);
            end
            WAIT_ACK: begin
                // ack_reg counts cycles since START, so the START cycle is part of the allowance.
                if (IN_DAC_BUSY) begin
                    state_next = WAIT_DONE;
                end else if (ack_reg == ACK_W'(ACK_TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    advance     = 1'b1;
                end else begin
                    ack_next = ack_reg + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!IN_DAC_BUSY) begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                OUT_FRAME_DONE = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (advance) begin
            if (chan_src[0]) begin
                state_next = ISSUE;
                bits_next  = word_a;
                addr_next  = ADDR_A;
                pend_next  = {chan_src[1], 1'b0};
            end else if (chan_src[1]) begin
                state_next = ISSUE;
                bits_next  = word_b;
                addr_next  = ADDR_B;
                pend_next  = 2'b00;
            end else begin
                state_next = DONE;
                pend_next  = 2'b00;
            end
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge IN_RESET) begin
        if (IN_RESET) begin
            state_reg    <= IDLE;
            dly_reg      <= '0;
            ack_reg      <= '0;
            pend_reg     <= 2'b00;
            bits_reg     <= '0;
            addr_reg     <= '0;
            sample_a_reg <= '0;
            sample_b_reg <= '0;
            overrun_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            dly_reg   <= dly_next;
            ack_reg   <= ack_next;
            pend_reg  <= pend_next;
            bits_reg  <= bits_next;
            addr_reg  <= addr_next;
            if (latch_en) begin
                sample_a_reg <= IN_SAMPLE_A;
                sample_b_reg <= IN_SAMPLE_B;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end
        end
    end

`ifdef SCHED_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge CLK_50MHZ or posedge IN_RESET) begin
        if (IN_RESET) begin
            drop_cnt_reg <= 8'h00;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign OUT_DROP_COUNT = drop_cnt_reg;
`endif

    assign OUT_SAMPLE_TICK = tick;
    assign OUT_DAC_BITS    = bits_reg;
    assign OUT_DAC_ADDR    = addr_reg;
    assign OUT_OVERRUN     = overrun_reg;
    assign OUT_TIMEOUT     = timeout_reg;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
`timescale 1ns/1ps
// Randomised self-checking bench for dac_frame_scheduler; a cycle-schedule reference model predicts every output.
module tb_dac_frame_scheduler;

    localparam int         TICK_DIV    = 1134;
    localparam int         LATCH_DELAY = 4;
    localparam int         ACK_TIMEOUT = 64;
    localparam logic [3:0] ADDR_A      = 4'h0;
    localparam logic [3:0] ADDR_B      = 4'h1;
    localparam int         MAX_BAD     = 10;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic [1:0]  mask = 2'b00;
    logic [11:0] sa   = 12'h000;
    logic [11:0] sb   = 12'h000;
    logic        busy = 1'b0;
    logic        tick, start, done, ovr, tmo;
    logic [11:0] bits;
    logic [3:0]  addr;
    logic [7:0]  drops;

    always #10 clk = ~clk;

    dac_frame_scheduler dut (
        .CLK_50MHZ      (clk),
        .IN_RESET       (rst),
        .IN_ENABLE      (en),
        .IN_CH_MASK     (mask),
        .IN_SAMPLE_A    (sa),
        .IN_SAMPLE_B    (sb),
        .IN_DAC_BUSY    (busy),
        .OUT_SAMPLE_TICK(tick),
        .OUT_DAC_START  (start),
        .OUT_DAC_BITS   (bits),
        .OUT_DAC_ADDR   (addr),
        .OUT_FRAME_DONE (done),
        .OUT_OVERRUN    (ovr),
        .OUT_TIMEOUT    (tmo)
`ifdef SCHED_DROP_CNT_EN
        ,
        .OUT_DROP_COUNT (drops)
`endif
    );

`ifndef SCHED_DROP_CNT_EN
    assign drops = 8'h00;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // stimulus configuration
    bit          want_rst    = 1'b1;
    bit          en_cfg      = 1'b1;
    int          en_low_until = 0;
    bit          mask_rand   = 1'b0;
    logic [1:0]  mask_fix    = 2'b11;
    bit          samp_rand   = 1'b0;
    logic [11:0] sa_fix      = 12'h000;
    logic [11:0] sb_fix      = 12'h000;
    int lat_min = 0, lat_max = 0, dur_min = 40, dur_max = 40;
    int tmo_pct = 0, stale_pct = 0, gap_pct = 0;
    int w0_lo = -1, w0_hi = -2, w1_lo = -1, w1_hi = -2;

    // observation bookkeeping
    int cyc = 0;
    int rel_cyc = -1, first_tick_cyc = -1, last_tick_cyc = -1;
    int last_start_cyc = -1, last_done_cyc = -1, tmo_rise_cyc = -1;
    int start_lat = -1, dut_done_cnt = 0;
    bit lat_pending = 1'b0, tmo_prev = 1'b0, saw_start = 1'b0;

    // reference model: absolute-cycle schedule of the current frame
    int          run = 0;
    bit          m_active = 1'b0, m_wait_ack = 1'b0, m_wait_done = 1'b0;
    int          m_latch_at = -1, m_issue_at = -1, m_done_at = -1;
    logic [15:0] m_q[$];
    logic [11:0] m_bits = 12'h000;
    logic [3:0]  m_addr = 4'h0;
    bit          m_ovr = 1'b0, m_tmo = 1'b0;
    int          m_drops = 0, frames_done = 0;

    task automatic schedule_next(input int c);
        if (m_q.size() > 0) m_issue_at = c;
        else                m_done_at  = c;
    endtask

    task automatic model_step();
        logic [31:0] got_v, exp_v;
        logic        e_tick, e_start, e_done;
        logic [7:0]  e_drops;
        logic [15:0] item;
        got_v = {3'b000, drops, tick, start, done, ovr, tmo, addr, bits};
        if (rst) begin
            run = 0; m_active = 0; m_wait_ack = 0; m_wait_done = 0;
            m_latch_at = -1; m_issue_at = -1; m_done_at = -1;
            m_q.delete(); m_bits = '0; m_addr = '0; m_ovr = 0; m_tmo = 0; m_drops = 0;
            check_eq($sformatf("reset_outs@%0d", cyc), got_v, 32'h0);
        end else begin
            e_tick = en && ((run % TICK_DIV) == TICK_DIV - 1);
            run = en ? run + 1 : 0;
            if (cyc == m_issue_at) begin
                item   = m_q.pop_front();
                m_addr = item[15:12];
                m_bits = item[11:0];
            end
            e_start = (cyc == m_issue_at);
            e_done  = (cyc == m_done_at);
`ifdef SCHED_DROP_CNT_EN
            e_drops = 8'(m_drops);
`else
            e_drops = 8'h00;
`endif
            exp_v = {3'b000, e_drops, e_tick, e_start, e_done, m_ovr, m_tmo, m_addr, m_bits};
            check_eq($sformatf("outs@%0d", cyc), got_v, exp_v);

            if (e_tick) begin
                if (m_active) begin
                    m_ovr = 1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_active   = 1;
                    m_latch_at = cyc + LATCH_DELAY + 1;
                end
            end
            if (cyc == m_latch_at) begin
                if (mask[0]) m_q.push_back({ADDR_A, sa});
                if (mask[1]) m_q.push_back({ADDR_B, sb});
                schedule_next(cyc + 1);
            end
            if (cyc == m_issue_at) begin
                m_wait_ack = 1;
            end else if (m_wait_ack) begin
                if (busy) begin
                    m_wait_ack  = 0;
                    m_wait_done = 1;
                end else if (cyc - m_issue_at == ACK_TIMEOUT - 1) begin
                    m_wait_ack = 0;
                    m_tmo      = 1;
                    schedule_next(cyc + 1);
                end
            end else if (m_wait_done) begin
                if (!busy) begin
                    m_wait_done = 0;
                    schedule_next(cyc + 1);
                end
            end
            if (cyc == m_done_at) begin
                m_active = 0;
                frames_done++;
                $display("frame %0d done at cycle %0d (bits=%h addr=%h ovr=%0d tmo=%0d)",
                         frames_done, cyc, m_bits, m_addr, m_ovr, m_tmo);
            end
        end
    endtask

    task automatic observe();
        if (rst) begin
            rel_cyc = -1; first_tick_cyc = -1; lat_pending = 0; tmo_prev = 0;
            w0_lo = -1; w0_hi = -2; w1_lo = -1; w1_hi = -2;
        end else begin
            if (rel_cyc < 0) rel_cyc = cyc;
            if (tick) begin
                if (first_tick_cyc < 0) first_tick_cyc = cyc;
                last_tick_cyc = cyc;
                lat_pending   = 1;
                if ($urandom_range(0, 99) < stale_pct) begin
                    w0_lo = cyc + 3;
                    w0_hi = cyc + 3 + $urandom_range(3, 10);
                end
                if ($urandom_range(0, 99) < gap_pct) en_low_until = cyc + 1 + $urandom_range(1, 50);
            end
            if (start) begin
                saw_start      = 1;
                last_start_cyc = cyc;
                if (lat_pending) begin
                    start_lat   = cyc - last_tick_cyc;
                    lat_pending = 0;
                end
                if ($urandom_range(0, 99) < tmo_pct) begin
                    w1_lo = -1; w1_hi = -2;
                end else begin
                    w1_lo = cyc + 1 + $urandom_range(lat_min, lat_max);
                    w1_hi = w1_lo + $urandom_range(dur_min, dur_max) - 1;
                end
            end
            if (done) begin
                dut_done_cnt++;
                last_done_cyc = cyc;
                if ($urandom_range(0, 99) < gap_pct) en_low_until = cyc + 1 + $urandom_range(1, 300);
            end
            if (tmo && !tmo_prev) tmo_rise_cyc = cyc;
            tmo_prev = tmo;
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst  = want_rst;
        en   = en_cfg && (cyc >= en_low_until);
        mask = mask_rand ? 2'($urandom_range(0, 3)) : mask_fix;
        sa   = samp_rand ? 12'($urandom) : sa_fix;
        sb   = samp_rand ? 12'($urandom) : sb_fix;
        busy = ((cyc >= w0_lo) && (cyc <= w0_hi)) || ((cyc >= w1_lo) && (cyc <= w1_hi));
        @(negedge clk);
        model_step();
        observe();
    endtask

    task automatic run_frames(input string name, input int nframes, input int budget);
        int start_cnt;
        int n;
        start_cnt = dut_done_cnt;
        n = 0;
        while ((dut_done_cnt - start_cnt) < nframes && n < budget && bad < MAX_BAD) begin
            run_cycle();
            n++;
        end
        check_eq({name, "_frames"}, dut_done_cnt - start_cnt, nframes);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) run_cycle();
        want_rst = 1'b0;

        // two channels, fixed samples, 40-cycle serializer words
        mask_fix = 2'b11; sa_fix = 12'h123; sb_fix = 12'hABC;
        run_frames("basic", 1, 1500);
        check_eq("first_tick", first_tick_cyc - rel_cyc, TICK_DIV - 1);
        check_eq("start_latency", start_lat, LATCH_DELAY + 2);
        check_eq("basic_flags", {ovr, tmo}, 2'b00);

        // empty mask: no words, frame done still pulses
        mask_fix = 2'b00;
        run_frames("empty", 1, 1500);
        check_eq("empty_done_latency", last_done_cyc - last_tick_cyc, LATCH_DELAY + 2);
        check_eq("empty_flags", {ovr, tmo}, 2'b00);

        // serializer busy longer than a frame period: next tick dropped
        mask_fix = 2'b01; dur_min = 1200; dur_max = 1200;
        run_frames("overrun", 1, 3000);
        check_eq("overrun_flag", ovr, 1'b1);
`ifdef SCHED_DROP_CNT_EN
        check_eq("drop_count", drops, 8'd1);
`endif

        want_rst = 1'b1;
        repeat (2) run_cycle();
        want_rst = 1'b0;

        // serializer never answers
        tmo_pct = 100;
        run_frames("timeout", 1, 1500);
        check_eq("timeout_latency", tmo_rise_cyc - last_start_cyc, ACK_TIMEOUT);
        check_eq("timeout_done", last_done_cyc - last_start_cyc, ACK_TIMEOUT);
        check_eq("timeout_flag", tmo, 1'b1);

        // reset while waiting for the serializer to finish a word
        tmo_pct = 0; dur_min = 40; dur_max = 40; mask_fix = 2'b11;
        saw_start = 0;
        n = 0;
        while (!saw_start && n < 1500 && bad < MAX_BAD) begin
            run_cycle();
            n++;
        end
        check_eq("mid_start_seen", saw_start, 1'b1);
        repeat (10) run_cycle();
        want_rst = 1'b1;
        run_cycle();
        check_eq("mid_reset_outs", {tick, start, done, ovr, tmo, addr, bits}, 21'h0);
        run_cycle();
        want_rst = 1'b0;
        run_frames("post_reset", 1, 1500);
        check_eq("post_reset_tick", first_tick_cyc - rel_cyc, TICK_DIV - 1);

        // randomised traffic
        mask_rand = 1; samp_rand = 1;
        lat_min = 0; lat_max = 8; dur_min = 1; dur_max = 120;
        tmo_pct = 10; stale_pct = 20; gap_pct = 30;
        run_frames("random", 10, 20000);
        check_eq("model_frames", frames_done, dut_done_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
